// File: rtl/mem_stage_lsu.sv
// rtl/mem_stage_lsu.sv - MEM-stage load/store unit issuing single-beat AXI reads and writes
//
// Purpose: accepts one decoded memory request per instruction, checks size and
// alignment, performs one AXI read (load) or write (store), and returns an
// extracted, sign/zero-extended load result. The pipeline is held with stall
// until the access completes.
//
// Ports:
//   clk, reset                      clock, asynchronous active-high reset
//   req_valid/req_load/req_store    request qualifiers from the MEM interstage register
//   req_funct3, req_addr, req_wdata size/signedness, effective address, store data
//   stall                           hold MEM and upstream, bubble into WB
//   resp_valid, resp_data, err      one-cycle completion pulse with held result/error
//   m_axi_ar*/r*                    read address / read data channels
//   m_axi_aw*/w*/b*                 write address / write data / write response channels
module mem_stage_lsu #(
  parameter int ADDR_WIDTH = 64,
  parameter int DATA_WIDTH = 64
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      req_valid,
  input  logic                      req_load,
  input  logic                      req_store,
  input  logic [2:0]                req_funct3,
  input  logic [ADDR_WIDTH-1:0]     req_addr,
  input  logic [DATA_WIDTH-1:0]     req_wdata,
  output logic                      stall,
  output logic                      resp_valid,
  output logic [DATA_WIDTH-1:0]     resp_data,
  output logic                      err,
  output logic [ADDR_WIDTH-1:0]     m_axi_araddr,
  output logic                      m_axi_arvalid,
  input  logic                      m_axi_arready,
  input  logic [DATA_WIDTH-1:0]     m_axi_rdata,
  input  logic [1:0]                m_axi_rresp,
  input  logic                      m_axi_rvalid,
  output logic                      m_axi_rready,
  output logic [ADDR_WIDTH-1:0]     m_axi_awaddr,
  output logic                      m_axi_awvalid,
  input  logic                      m_axi_awready,
  output logic [DATA_WIDTH-1:0]     m_axi_wdata,
  output logic [DATA_WIDTH/8-1:0]   m_axi_wstrb,
  output logic                      m_axi_wvalid,
  input  logic                      m_axi_wready,
  input  logic [1:0]                m_axi_bresp,
  input  logic                      m_axi_bvalid,
  output logic                      m_axi_bready
);

  typedef enum logic [2:0] {
    S_IDLE, S_RD_ADDR, S_RD_DATA, S_WR_REQ, S_WR_RESP, S_DONE
  } state_t;

  state_t                    state_q, state_d;
  logic [2:0]                funct3_q, funct3_d;
  logic [2:0]                boff_q, boff_d;
  logic [ADDR_WIDTH-1:0]     addr_q, addr_d;
  logic [DATA_WIDTH-1:0]     wdata_q, wdata_d;
  logic [DATA_WIDTH/8-1:0]   wstrb_q, wstrb_d;
  logic                      aw_done_q, aw_done_d;
  logic                      w_done_q, w_done_d;
  logic [DATA_WIDTH-1:0]     resp_data_q, resp_data_d;
  logic                      err_q, err_d;

  logic                      accept;
  logic                      misaligned;
  logic                      illegal;
  logic [7:0]                strb_base;
  logic [63:0]               rshift;
  logic [63:0]               load_ext;

  assign accept = req_valid && (req_load || req_store);

  // Byte lanes covered by an access of 1 << funct3[1:0] bytes at lane 0.
  always_comb begin
    strb_base = 8'h01;
    misaligned = 1'b0;
    case (req_funct3[1:0])
      2'b00: begin strb_base = 8'h01; misaligned = 1'b0; end
      2'b01: begin strb_base = 8'h03; misaligned = req_addr[0]; end
      2'b10: begin strb_base = 8'h0F; misaligned = |req_addr[1:0]; end
      default: begin strb_base = 8'hFF; misaligned = |req_addr[2:0]; end
    endcase
  end

  // Loads reject only 111; stores have no unsigned variants.
  assign illegal = req_load ? (req_funct3 == 3'b111) : req_funct3[2];

  // Move the addressed byte to lane 0, then extend to the access size.
  assign rshift = m_axi_rdata >> {boff_q, 3'b000};

  always_comb begin
    load_ext = '0;
    case (funct3_q)
      3'b000:  load_ext = {{56{rshift[7]}}, rshift[7:0]};
      3'b001:  load_ext = {{48{rshift[15]}}, rshift[15:0]};
      3'b010:  load_ext = {{32{rshift[31]}}, rshift[31:0]};
      3'b011:  load_ext = rshift;
      3'b100:  load_ext = {56'b0, rshift[7:0]};
      3'b101:  load_ext = {48'b0, rshift[15:0]};
      3'b110:  load_ext = {32'b0, rshift[31:0]};
      default: load_ext = '0;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    funct3_d    = funct3_q;
    boff_d      = boff_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    wstrb_d     = wstrb_q;
    aw_done_d   = aw_done_q;
    w_done_d    = w_done_q;
    resp_data_d = resp_data_q;
    err_d       = err_q;
    stall       = 1'b0;
    case (state_q)
      S_IDLE: begin
        // Gated with reset so every output reads 0 while reset is held.
        stall = accept && !reset;
        if (accept) begin
          funct3_d  = req_funct3;
          boff_d    = req_addr[2:0];
          addr_d    = {req_addr[ADDR_WIDTH-1:3], 3'b000};
          wdata_d   = req_wdata << {req_addr[2:0], 3'b000};
          wstrb_d   = strb_base << req_addr[2:0];
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
          if (misaligned || illegal) begin
            err_d       = 1'b1;
            resp_data_d = '0;
            state_d     = S_DONE;
          end else begin
            state_d = req_load ? S_RD_ADDR : S_WR_REQ;
          end
        end
      end
      S_RD_ADDR: begin
        stall = 1'b1;
        if (m_axi_arready) state_d = S_RD_DATA;
      end
      S_RD_DATA: begin
        stall = 1'b1;
        if (m_axi_rvalid) begin
          err_d       = (m_axi_rresp != 2'b00);
          resp_data_d = (m_axi_rresp != 2'b00) ? '0 : load_ext;
          state_d     = S_DONE;
        end
      end
      S_WR_REQ: begin
        stall = 1'b1;
        // AW and W complete independently; leave once both have handshaken.
        aw_done_d = aw_done_q || m_axi_awready;
        w_done_d  = w_done_q || m_axi_wready;
        if (aw_done_d && w_done_d) state_d = S_WR_RESP;
      end
      S_WR_RESP: begin
        stall = 1'b1;
        if (m_axi_bvalid) begin
          err_d       = (m_axi_bresp != 2'b00);
          resp_data_d = '0;
          state_d     = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      funct3_q    <= '0;
      boff_q      <= '0;
      addr_q      <= '0;
      wdata_q     <= '0;
      wstrb_q     <= '0;
      aw_done_q   <= 1'b0;
      w_done_q    <= 1'b0;
      resp_data_q <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      funct3_q    <= funct3_d;
      boff_q      <= boff_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      wstrb_q     <= wstrb_d;
      aw_done_q   <= aw_done_d;
      w_done_q    <= w_done_d;
      resp_data_q <= resp_data_d;
      err_q       <= err_d;
    end
  end

  assign resp_valid    = (state_q == S_DONE);
  assign resp_data     = resp_data_q;
  assign err           = err_q;
  assign m_axi_araddr  = addr_q;
  assign m_axi_arvalid = (state_q == S_RD_ADDR);
  assign m_axi_rready  = (state_q == S_RD_DATA);
  assign m_axi_awaddr  = addr_q;
  assign m_axi_awvalid = (state_q == S_WR_REQ) && !aw_done_q;
  assign m_axi_wdata   = wdata_q;
  assign m_axi_wstrb   = wstrb_q;
  assign m_axi_wvalid  = (state_q == S_WR_REQ) && !w_done_q;
  assign m_axi_bready  = (state_q == S_WR_RESP);

endmodule

// File: tb/tb_mem_stage_lsu.sv
// tb/tb_mem_stage_lsu.sv - directed self-checking bench for mem_stage_lsu
module tb_mem_stage_lsu;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid, req_load, req_store;
  logic [2:0]  req_funct3;
  logic [63:0] req_addr, req_wdata;
  logic        stall, resp_valid, err;
  logic [63:0] resp_data;
  logic [63:0] m_axi_araddr, m_axi_rdata, m_axi_awaddr, m_axi_wdata;
  logic        m_axi_arvalid, m_axi_arready, m_axi_rvalid, m_axi_rready;
  logic [1:0]  m_axi_rresp, m_axi_bresp;
  logic        m_axi_awvalid, m_axi_awready, m_axi_wvalid, m_axi_wready;
  logic [7:0]  m_axi_wstrb;
  logic        m_axi_bvalid, m_axi_bready;

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  mem_stage_lsu #(.ADDR_WIDTH(64), .DATA_WIDTH(64)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_load(req_load), .req_store(req_store),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .stall(stall), .resp_valid(resp_valid), .resp_data(resp_data), .err(err),
    .m_axi_araddr(m_axi_araddr), .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready),
    .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp), .m_axi_rvalid(m_axi_rvalid),
    .m_axi_rready(m_axi_rready),
    .m_axi_awaddr(m_axi_awaddr), .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready),
    .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb), .m_axi_wvalid(m_axi_wvalid),
    .m_axi_wready(m_axi_wready),
    .m_axi_bresp(m_axi_bresp), .m_axi_bvalid(m_axi_bvalid), .m_axi_bready(m_axi_bready)
  );

  task automatic clear_inputs();
    req_valid = 0; req_load = 0; req_store = 0; req_funct3 = 0;
    req_addr = 0; req_wdata = 0;
    m_axi_arready = 0; m_axi_rdata = 0; m_axi_rresp = 0; m_axi_rvalid = 0;
    m_axi_awready = 0; m_axi_wready = 0; m_axi_bresp = 0; m_axi_bvalid = 0;
  endtask

  // Present a load in the current IDLE cycle and act as a zero-wait slave.
  // Leaves the bench one cycle after DONE (back in IDLE).
  task automatic load_txn(input logic [63:0] addr, input logic [2:0] f3,
                          input logic [63:0] rdata, input logic [1:0] rresp,
                          output logic stall0, output logic arv_seen,
                          output logic [63:0] araddr_o, output int lat,
                          output logic [63:0] data_o, output logic err_o,
                          output logic stall_done, output logic rv_after);
    req_valid = 1; req_load = 1; req_store = 0; req_funct3 = f3;
    req_addr = addr; req_wdata = 0;
    #1 stall0 = stall;
    arv_seen = 0; araddr_o = 0; lat = -1; data_o = 0; err_o = 0;
    stall_done = 1; rv_after = 1;
    for (int k = 1; k <= 50; k++) begin
      @(posedge clk); #1;
      req_valid = 0; req_load = 0;
      m_axi_arready = 0; m_axi_rvalid = 0; m_axi_rdata = 0; m_axi_rresp = 0;
      if (m_axi_arvalid) begin arv_seen = 1; araddr_o = m_axi_araddr; m_axi_arready = 1; end
      if (m_axi_rready) begin m_axi_rvalid = 1; m_axi_rdata = rdata; m_axi_rresp = rresp; end
      if (resp_valid) begin
        lat = k; data_o = resp_data; err_o = err; stall_done = stall;
        break;
      end
    end
    m_axi_arready = 0; m_axi_rvalid = 0;
    @(posedge clk); #1;
    rv_after = resp_valid;
  endtask

  // Present a store and act as a slave with per-channel ready/response delays.
  task automatic store_txn(input logic [63:0] addr, input logic [2:0] f3,
                           input logic [63:0] wd, input int aw_delay, input int w_delay,
                           input int b_delay, input logic [1:0] bresp,
                           output logic [63:0] awaddr_o, output logic [63:0] wdata_o,
                           output logic [7:0] wstrb_o, output int aw_cyc, output int w_cyc,
                           output int b_cyc, output int stall_gap, output int lat,
                           output logic err_o, output logic [63:0] data_o,
                           output logic rv_after);
    req_valid = 1; req_load = 0; req_store = 1; req_funct3 = f3;
    req_addr = addr; req_wdata = wd;
    awaddr_o = 0; wdata_o = 0; wstrb_o = 0; aw_cyc = 0; w_cyc = 0; b_cyc = 0;
    stall_gap = 0; lat = -1; err_o = 0; data_o = 0; rv_after = 1;
    for (int k = 1; k <= 50; k++) begin
      @(posedge clk); #1;
      req_valid = 0; req_store = 0;
      m_axi_awready = 0; m_axi_wready = 0; m_axi_bvalid = 0; m_axi_bresp = 0;
      if (m_axi_awvalid) begin
        if (aw_cyc == 0) awaddr_o = m_axi_awaddr;
        aw_cyc++;
        m_axi_awready = (aw_cyc > aw_delay);
      end
      if (m_axi_wvalid) begin
        if (w_cyc == 0) begin wdata_o = m_axi_wdata; wstrb_o = m_axi_wstrb; end
        w_cyc++;
        m_axi_wready = (w_cyc > w_delay);
      end
      if (m_axi_bready) begin
        b_cyc++;
        if (b_cyc > b_delay) begin m_axi_bvalid = 1; m_axi_bresp = bresp; end
      end
      if (resp_valid) begin
        lat = k; err_o = err; data_o = resp_data;
        break;
      end
      if (!stall) stall_gap++;
    end
    m_axi_awready = 0; m_axi_wready = 0; m_axi_bvalid = 0;
    @(posedge clk); #1;
    rv_after = resp_valid;
  endtask

  task automatic test_reset();
    clear_inputs();
    reset = 1;
    repeat (2) @(posedge clk);
    #1;
    total++; if (stall !== 1'b0) $display("FAIL rst_stall got %b want 0", stall); else passed++;
    total++; if (resp_valid !== 1'b0) $display("FAIL rst_resp_valid got %b want 0", resp_valid); else passed++;
    total++; if ({m_axi_arvalid, m_axi_rready, m_axi_awvalid, m_axi_wvalid, m_axi_bready} !== 5'b0)
      $display("FAIL rst_bus_valids got %b want 00000",
               {m_axi_arvalid, m_axi_rready, m_axi_awvalid, m_axi_wvalid, m_axi_bready});
    else passed++;
    total++; if ({resp_data, err, m_axi_araddr, m_axi_wstrb} !== '0)
      $display("FAIL rst_data got %h/%b/%h/%h want zeros", resp_data, err, m_axi_araddr, m_axi_wstrb);
    else passed++;
    reset = 0;
    @(posedge clk); #1;
  endtask

  task automatic test_ld();
    logic s0, arv, e, sd, rva; logic [63:0] ara, d; int lat;
    load_txn(64'h1008, 3'b011, 64'h1122334455667788, 2'b00, s0, arv, ara, lat, d, e, sd, rva);
    total++; if (s0 !== 1'b1) $display("FAIL ld_stall_accept got %b want 1", s0); else passed++;
    total++; if (ara !== 64'h1008) $display("FAIL ld_araddr got %h want 1008", ara); else passed++;
    total++; if (lat !== 3) $display("FAIL ld_latency got %0d want 3", lat); else passed++;
    total++; if (d !== 64'h1122334455667788) $display("FAIL ld_data got %h want 1122334455667788", d); else passed++;
    total++; if (e !== 1'b0) $display("FAIL ld_err got %b want 0", e); else passed++;
    total++; if (sd !== 1'b0) $display("FAIL ld_stall_done got %b want 0", sd); else passed++;
    total++; if (rva !== 1'b0) $display("FAIL ld_resp_once got %b want 0", rva); else passed++;
    repeat (3) @(posedge clk);
    #1;
    total++; if (resp_data !== 64'h1122334455667788) $display("FAIL ld_data_hold got %h want 1122334455667788", resp_data); else passed++;
  endtask

  task automatic test_back_to_back();
    logic s0, arv, e, sd, rva; logic [63:0] ara, d; int lat;
    load_txn(64'h1005, 3'b000, 64'h0000800000000000, 2'b00, s0, arv, ara, lat, d, e, sd, rva);
    total++; if (ara !== 64'h1000) $display("FAIL lb_araddr got %h want 1000", ara); else passed++;
    total++; if (d !== 64'hFFFFFFFFFFFFFF80) $display("FAIL lb_data got %h want ffffffffffffff80", d); else passed++;
    load_txn(64'h1005, 3'b100, 64'h0000800000000000, 2'b00, s0, arv, ara, lat, d, e, sd, rva);
    total++; if (lat !== 3) $display("FAIL lbu_latency got %0d want 3", lat); else passed++;
    total++; if (d !== 64'h80) $display("FAIL lbu_data got %h want 80", d); else passed++;
    load_txn(64'h100C, 3'b010, 64'h89ABCDEF01234567, 2'b00, s0, arv, ara, lat, d, e, sd, rva);
    total++; if (d !== 64'hFFFFFFFF89ABCDEF) $display("FAIL lw_hi_data got %h want ffffffff89abcdef", d); else passed++;
    load_txn(64'h100E, 3'b101, 64'h89ABCDEF01234567, 2'b00, s0, arv, ara, lat, d, e, sd, rva);
    total++; if (d !== 64'h89AB) $display("FAIL lhu_data got %h want 89ab", d); else passed++;
  endtask

  task automatic test_errors();
    logic s0, arv, e, sd, rva; logic [63:0] ara, d; int lat;
    load_txn(64'h1002, 3'b010, 64'hFFFFFFFFFFFFFFFF, 2'b00, s0, arv, ara, lat, d, e, sd, rva);
    total++; if (arv !== 1'b0) $display("FAIL mis_arvalid got %b want 0", arv); else passed++;
    total++; if (lat !== 1) $display("FAIL mis_latency got %0d want 1", lat); else passed++;
    total++; if ({e, d} !== {1'b1, 64'h0}) $display("FAIL mis_err_data got %b/%h want 1/0", e, d); else passed++;
    load_txn(64'h1000, 3'b111, 64'hFFFFFFFFFFFFFFFF, 2'b00, s0, arv, ara, lat, d, e, sd, rva);
    total++; if ({arv, e} !== 2'b01) $display("FAIL ill_f3 got arv=%b err=%b want 0/1", arv, e); else passed++;
    load_txn(64'h1010, 3'b011, 64'h1234567812345678, 2'b10, s0, arv, ara, lat, d, e, sd, rva);
    total++; if (lat !== 3) $display("FAIL rresp_latency got %0d want 3", lat); else passed++;
    total++; if ({e, d} !== {1'b1, 64'h0}) $display("FAIL rresp_err_data got %b/%h want 1/0", e, d); else passed++;
  endtask

  task automatic test_non_mem();
    req_valid = 1; req_load = 0; req_store = 0; req_funct3 = 3'b011; req_addr = 64'h1000;
    #1;
    total++; if (stall !== 1'b0) $display("FAIL nonmem_stall got %b want 0", stall); else passed++;
    req_valid = 0; req_load = 1;
    #1;
    total++; if (stall !== 1'b0) $display("FAIL bubble_stall got %b want 0", stall); else passed++;
    @(posedge clk); #1;
    total++; if ({resp_valid, m_axi_arvalid, m_axi_awvalid} !== 3'b0)
      $display("FAIL nonmem_activity got %b want 000", {resp_valid, m_axi_arvalid, m_axi_awvalid});
    else passed++;
    clear_inputs();
  endtask

  task automatic test_store();
    logic [63:0] awa, wd, d; logic [7:0] ws; int awc, wc, bc, gap, lat; logic e, rva;
    store_txn(64'h1006, 3'b001, 64'hABCD, 0, 0, 5, 2'b00, awa, wd, ws, awc, wc, bc, gap, lat, e, d, rva);
    total++; if (awa !== 64'h1000) $display("FAIL sh_awaddr got %h want 1000", awa); else passed++;
    total++; if (ws !== 8'hC0) $display("FAIL sh_wstrb got %h want c0", ws); else passed++;
    total++; if (wd !== 64'hABCD000000000000) $display("FAIL sh_wdata got %h want abcd000000000000", wd); else passed++;
    total++; if (lat !== 8) $display("FAIL sh_latency got %0d want 8", lat); else passed++;
    total++; if (gap !== 0) $display("FAIL sh_stall_gap got %0d want 0", gap); else passed++;
    total++; if (bc !== 6) $display("FAIL sh_bready_cycles got %0d want 6", bc); else passed++;
    store_txn(64'h2004, 3'b010, 64'hDEADBEEF, 2, 0, 0, 2'b00, awa, wd, ws, awc, wc, bc, gap, lat, e, d, rva);
    total++; if (wc !== 1) $display("FAIL sw_wvalid_cycles got %0d want 1", wc); else passed++;
    total++; if (awc !== 3) $display("FAIL sw_awvalid_cycles got %0d want 3", awc); else passed++;
    total++; if (bc !== 1) $display("FAIL sw_bready_cycles got %0d want 1", bc); else passed++;
    total++; if (lat !== 5) $display("FAIL sw_latency got %0d want 5", lat); else passed++;
    total++; if (rva !== 1'b0) $display("FAIL sw_resp_once got %b want 0", rva); else passed++;
    total++; if ({ws, wd} !== {8'hF0, 64'hDEADBEEF00000000}) $display("FAIL sw_lanes got %h/%h want f0/deadbeef00000000", ws, wd); else passed++;
    store_txn(64'h3000, 3'b011, 64'h55, 0, 0, 0, 2'b11, awa, wd, ws, awc, wc, bc, gap, lat, e, d, rva);
    total++; if ({lat, e} !== {32'd3, 1'b1}) $display("FAIL sd_bresp got lat=%0d err=%b want 3/1", lat, e); else passed++;
  endtask

  task automatic test_reset_midflight();
    logic s0, arv, e, sd, rva; logic [63:0] ara, d; int lat;
    req_valid = 1; req_load = 1; req_funct3 = 3'b011; req_addr = 64'h1018;
    @(posedge clk); #1;
    req_valid = 0; req_load = 0;
    m_axi_arready = 1;
    @(posedge clk); #1;
    m_axi_arready = 0;
    total++; if (m_axi_rready !== 1'b1) $display("FAIL mid_rready got %b want 1", m_axi_rready); else passed++;
    reset = 1;
    #1;
    total++; if ({m_axi_arvalid, m_axi_rready, m_axi_awvalid, m_axi_wvalid, m_axi_bready, stall, resp_valid} !== 7'b0)
      $display("FAIL mid_reset_outputs got %b want 0000000",
               {m_axi_arvalid, m_axi_rready, m_axi_awvalid, m_axi_wvalid, m_axi_bready, stall, resp_valid});
    else passed++;
    @(posedge clk); #1;
    reset = 0;
    @(posedge clk); #1;
    load_txn(64'h4010, 3'b011, 64'hCAFEF00D12345678, 2'b00, s0, arv, ara, lat, d, e, sd, rva);
    total++; if ({lat, ara} !== {32'd3, 64'h4010}) $display("FAIL post_rst_ld got lat=%0d araddr=%h want 3/4010", lat, ara); else passed++;
    total++; if ({e, d} !== {1'b0, 64'hCAFEF00D12345678}) $display("FAIL post_rst_data got %b/%h want 0/cafef00d12345678", e, d); else passed++;
  endtask

  initial begin
    test_reset();
    test_ld();
    test_back_to_back();
    test_errors();
    test_non_mem();
    test_store();
    test_reset_midflight();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
